estimador_state_update: RTL and testbench

- Downstream consumer of the B·u row stage. It takes the three saturated Q7.14 products temp3[0..2] and forms the next estimator state x_next = sat(A·x_hat + temp3).
- Holds x_hat internally and uses one shared 21x21 signed multiplier, sequenced row by row.
- Its x_hat outputs feed the next mvmult pass and the MPC core.

---
 rtl/estimador_pkg.sv | 27 ++
 rtl/estimador_state_update_if.sv | 31 +++
 rtl/estimador_sat_round.sv | 30 +++
 rtl/estimador_state_update.sv | 165 ++++++++++++++++
 tb/tb_estimador_state_update.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/estimador_pkg.sv
// Shared types and constants for the estimator state update: Q7.14 word,
// 44-bit accumulator, saturation limits and FSM encoding.
package estimador_pkg;

    localparam int W     = 21;
    localparam int FRAC  = 14;
    localparam int ACC_W = 44;

    localparam logic signed [W-1:0] SAT_MAX = 21'd1048575;
    localparam logic signed [W-1:0] SAT_MIN = 21'h100000;

    typedef logic signed [W-1:0]     word_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_SAT,
        S_DONE
    } state_t;

    // Aligns a Q7.14 word with the Q14.28 accumulator (sign-extend, shift by FRAC).
    function automatic acc_t bu_to_acc(input word_t v);
        return {{(ACC_W-W-FRAC){v[W-1]}}, v, {FRAC{1'b0}}};
    endfunction

endpackage

// File: rtl/estimador_state_update_if.sv
// Control handshake and data bus between the estimator state update block and
// its requester.
interface estimador_state_update_if;
    import estimador_pkg::*;

    logic  ap_start;
    logic  ap_ready;
    logic  ap_done;
    logic  ap_idle;
    word_t bu_0;
    word_t bu_1;
    word_t bu_2;
    logic  x_init_we;
    word_t x_init_0;
    word_t x_init_1;
    word_t x_init_2;
    word_t x_hat_0;
    word_t x_hat_1;
    word_t x_hat_2;

    modport master (
        output ap_start, bu_0, bu_1, bu_2, x_init_we, x_init_0, x_init_1, x_init_2,
        input  ap_ready, ap_done, ap_idle, x_hat_0, x_hat_1, x_hat_2
    );

    modport slave (
        input  ap_start, bu_0, bu_1, bu_2, x_init_we, x_init_0, x_init_1, x_init_2,
        output ap_ready, ap_done, ap_idle, x_hat_0, x_hat_1, x_hat_2
    );

endinterface

// File: rtl/estimador_sat_round.sv
// Rounds a Q14.28 accumulator to Q7.14 (half up) and saturates to the W-bit
// range; flags when the limit was applied.
module estimador_sat_round
    import estimador_pkg::*;
(
    input  acc_t  acc,
    output word_t q,
    output logic  sat_hit
);

    // One extra bit above the shifted accumulator absorbs the rounding carry.
    logic signed [ACC_W-FRAC:0] rnd;
    logic                       pos_ovf;
    logic                       neg_ovf;

    always_comb begin
        rnd     = $signed({acc[ACC_W-1], acc[ACC_W-1:FRAC]})
                + $signed({{(ACC_W-FRAC){1'b0}}, acc[FRAC-1]});
        pos_ovf = !rnd[ACC_W-FRAC] && (|rnd[ACC_W-FRAC-1:W-1]);
        neg_ovf =  rnd[ACC_W-FRAC] && !(&rnd[ACC_W-FRAC-1:W-1]);
        sat_hit = pos_ovf || neg_ovf;
        if (pos_ovf)
            q = SAT_MAX;
        else if (neg_ovf)
            q = SAT_MIN;
        else
            q = rnd[W-1:0];
    end

endmodule

// File: rtl/estimador_state_update.sv
// Estimator state update x_hat <= sat(A*x_hat + bu), computed row by row
// through one shared 21x21 signed multiplier.
module estimador_state_update
    import estimador_pkg::*;
#(
    parameter word_t A00 = 21'sd16384,
    parameter word_t A01 = 21'sd164,
    parameter word_t A02 = 21'sd0,
    parameter word_t A10 = 21'sd0,
    parameter word_t A11 = 21'sd16220,
    parameter word_t A12 = 21'sd47,
    parameter word_t A20 = 21'sd0,
    parameter word_t A21 = 21'sd0,
    parameter word_t A22 = 21'sd16384
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    estimador_state_update_if.slave   bus
);

    state_t              state;
    state_t              state_nxt;
    logic                start_acc;
    logic [1:0]          row;
    logic [1:0]          col;
    logic [1:0]          row_inc;
    acc_t                acc;
    word_t               x_hat  [3];
    word_t               x_next [3];
    word_t               bu_q   [3];
    word_t               coef;
    word_t               xh_sel;
    logic signed [2*W-1:0] prod;
    word_t               sat_q;
    logic                unused_sat_hit;

    assign row_inc = row + 2'd1;

    // Coefficient and operand select for the shared multiplier; always reads the
    // committed x_hat so rows never see a partially updated state.
    always_comb begin
        coef = '0;
        case ({row, col})
            4'h0: coef = A00;
            4'h1: coef = A01;
            4'h2: coef = A02;
            4'h4: coef = A10;
            4'h5: coef = A11;
            4'h6: coef = A12;
            4'h8: coef = A20;
            4'h9: coef = A21;
            4'hA: coef = A22;
            default: coef = '0;
        endcase
        xh_sel = '0;
        case (col)
            2'd0:    xh_sel = x_hat[0];
            2'd1:    xh_sel = x_hat[1];
            2'd2:    xh_sel = x_hat[2];
            default: xh_sel = '0;
        endcase
        prod = coef * xh_sel;
    end

    estimador_sat_round u_sat (
        .acc     (acc),
        .q       (sat_q),
        .sat_hit (unused_sat_hit)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: every branch of this block assigns defaults first; a missed path
    // would otherwise infer a latch.
    always_comb begin
        state_nxt    = state;
        start_acc    = 1'b0;
        bus.ap_ready = 1'b0;
        bus.ap_done  = 1'b0;
        bus.ap_idle  = 1'b0;
        case (state)
            S_IDLE: begin
                bus.ap_idle = 1'b1;
                // A state load takes priority; the requester keeps ap_start high.
                if (!bus.x_init_we && bus.ap_start) begin
                    start_acc    = 1'b1;
                    bus.ap_ready = 1'b1;
                    state_nxt    = S_MAC;
                end
            end
            S_MAC: begin
                if (col == 2'd2)
                    state_nxt = S_SAT;
            end
            S_SAT: begin
                state_nxt = (row == 2'd2) ? S_DONE : S_MAC;
            end
            S_DONE: begin
                bus.ap_done = 1'b1;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: the three-entry buffers are small enough to reset along with the
    // datapath, so a mid-update reset leaves no stale partial result.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            row <= '0;
            col <= '0;
            acc <= '0;
            for (int k = 0; k < 3; k++) begin
                x_hat[k]  <= '0;
                x_next[k] <= '0;
                bu_q[k]   <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.x_init_we) begin
                        x_hat[0] <= bus.x_init_0;
                        x_hat[1] <= bus.x_init_1;
                        x_hat[2] <= bus.x_init_2;
                    end else if (start_acc) begin
                        bu_q[0] <= bus.bu_0;
                        bu_q[1] <= bus.bu_1;
                        bu_q[2] <= bus.bu_2;
                        row     <= '0;
                        col     <= '0;
                        acc     <= bu_to_acc(bus.bu_0);
                    end
                end
                S_MAC: begin
                    acc <= acc + acc_t'(prod);
                    col <= (col == 2'd2) ? 2'd0 : col + 2'd1;
                end
                S_SAT: begin
                    x_next[row] <= sat_q;
                    if (row != 2'd2) begin
                        row <= row_inc;
                        acc <= bu_to_acc(bu_q[row_inc]);
                    end
                end
                S_DONE: begin
                    for (int k = 0; k < 3; k++)
                        x_hat[k] <= x_next[k];
                end
                default: ;
            endcase
        end
    end

    assign bus.x_hat_0 = x_hat[0];
    assign bus.x_hat_1 = x_hat[1];
    assign bus.x_hat_2 = x_hat[2];

endmodule

// File: tb/tb_estimador_state_update.sv
// Directed bench for estimador_state_update: reset, nominal, rounding,
// saturation, start/load collision, busy-input immunity and mid-update reset.
module tb_estimador_state_update;
    import estimador_pkg::*;

    logic ap_clk;
    logic ap_rst;
    int   vectors     = 0;
    int   miscompares = 0;

    estimador_state_update_if bus ();

    estimador_state_update dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic load_x(input int x0, input int x1, input int x2);
        bus.x_init_we = 1'b1;
        bus.x_init_0  = W'(x0);
        bus.x_init_1  = W'(x1);
        bus.x_init_2  = W'(x2);
        step();
        bus.x_init_we = 1'b0;
    endtask

    // Starts one update from IDLE (called just after an edge) and checks the
    // handshake timing and the committed state. With noise set, ap_start,
    // x_init_we and bu are driven with junk while the block is busy.
    task automatic do_update(input string tag, input int b0, input int b1, input int b2,
                             input int e0, input int e1, input int e2, input bit noise);
        int n;
        bus.bu_0     = W'(b0);
        bus.bu_1     = W'(b1);
        bus.bu_2     = W'(b2);
        bus.ap_start = 1'b1;
        #1;
        check({tag, "_ready0"}, bus.ap_ready, 1);
        step();
        bus.ap_start  = noise;
        bus.x_init_we = noise;
        if (noise) begin
            bus.x_init_0 = 21'sd777;
            bus.x_init_1 = 21'sd777;
            bus.x_init_2 = 21'sd777;
            bus.bu_0     = 21'sd12345;
            bus.bu_1     = 21'sd12345;
            bus.bu_2     = 21'sd12345;
        end
        #1;
        check({tag, "_ready1"}, bus.ap_ready, 0);
        n = 1;
        while (!bus.ap_done && n < 40) begin
            step();
            n++;
        end
        bus.ap_start  = 1'b0;
        bus.x_init_we = 1'b0;
        check({tag, "_done_cycle"}, n, 13);
        step();
        check({tag, "_x0"}, bus.x_hat_0, e0);
        check({tag, "_x1"}, bus.x_hat_1, e1);
        check({tag, "_x2"}, bus.x_hat_2, e2);
        check({tag, "_idle"}, bus.ap_idle, 1);
        check({tag, "_done_pulse"}, bus.ap_done, 0);
    endtask

    initial begin
        int dn;
        bus.ap_start  = 1'b0;
        bus.x_init_we = 1'b0;
        bus.x_init_0  = '0;
        bus.x_init_1  = '0;
        bus.x_init_2  = '0;
        bus.bu_0      = '0;
        bus.bu_1      = '0;
        bus.bu_2      = '0;
        ap_rst        = 1'b0;

        // Asynchronous reset before the first clock edge.
        #1 ap_rst = 1'b1;
        #1;
        check("rst_x0", bus.x_hat_0, 0);
        check("rst_x1", bus.x_hat_1, 0);
        check("rst_x2", bus.x_hat_2, 0);
        check("rst_idle", bus.ap_idle, 1);
        check("rst_done", bus.ap_done, 0);
        check("rst_ready", bus.ap_ready, 0);
        step();
        ap_rst = 1'b0;
        step();

        // Nominal: 16384*16384>>14 + 7479 = 23863; row1 = 47; row2 = 0.
        load_x(16384, 0, 0);
        do_update("nom", 7479, 47, 0, 23863, 47, 0, 1'b0);

        // Rounding: 164*50 = 8200 -> 0.5005 -> 1; 16220*50 = 811000 -> 49.4995 -> 49.
        load_x(0, 50, 0);
        do_update("rnd_up", 0, 0, 0, 1, 49, 0, 1'b0);
        // 164*49 = 8036 -> 0.49 -> 0; 16220*49 = 794780 -> 48.51 -> 49.
        load_x(0, 49, 0);
        do_update("rnd_dn", 0, 0, 0, 0, 49, 0, 1'b0);
        // Negative: -8200 -> -0.5005 -> -1; -811000 -> -49.4995 -> -49.
        load_x(0, -50, 0);
        do_update("rnd_neg", 0, 0, 0, -1, -49, 0, 1'b0);
        // Column 2: 47*200 = 9400 -> 0.57 -> 1; 16384*200 -> 200.
        load_x(0, 0, 200);
        do_update("col2", 0, 0, 0, 0, 1, 200, 1'b0);

        // Saturation at both limits.
        load_x(1048575, 0, 0);
        do_update("sat_pos", 16384, 0, 0, 1048575, 0, 0, 1'b0);
        load_x(-1048576, 0, 0);
        do_update("sat_neg", -1, 0, 0, -1048576, 0, 0, 1'b0);
        // Extreme inputs on every row must not wrap the accumulator.
        load_x(1048575, 1048575, 1048575);
        do_update("ext_pos", 1048575, 1048575, 1048575, 1048575, 1048575, 1048575, 1'b0);
        load_x(-1048576, -1048576, -1048576);
        do_update("ext_neg", -1048576, -1048576, -1048576, -1048576, -1048576, -1048576, 1'b0);

        // Busy immunity: junk start/load/bu during the update changes nothing.
        load_x(16384, 0, 0);
        do_update("busy", 7479, 47, 0, 23863, 47, 0, 1'b1);

        // Load and start together: load wins, start taken the following cycle.
        bus.x_init_we = 1'b1;
        bus.x_init_0  = 21'sd16384;
        bus.x_init_1  = 21'sd0;
        bus.x_init_2  = 21'sd0;
        bus.ap_start  = 1'b1;
        #1;
        check("coll_ready", bus.ap_ready, 0);
        step();
        bus.x_init_we = 1'b0;
        check("coll_loaded", bus.x_hat_0, 16384);
        do_update("coll", 0, 0, 0, 16384, 0, 0, 1'b0);

        // Reset in cycle 6 of an update aborts it with no ap_done.
        load_x(16384, 0, 0);
        bus.bu_0     = 21'sd7479;
        bus.ap_start = 1'b1;
        #1;
        check("mid_ready", bus.ap_ready, 1);
        step();
        bus.ap_start = 1'b0;
        repeat (5) step();
        #2 ap_rst = 1'b1;
        #1;
        check("mid_x0", bus.x_hat_0, 0);
        check("mid_idle", bus.ap_idle, 1);
        check("mid_done", bus.ap_done, 0);
        #2 ap_rst = 1'b0;
        dn = 0;
        repeat (20) begin
            step();
            if (bus.ap_done) dn++;
        end
        check("mid_no_done", dn, 0);
        load_x(16384, 0, 0);
        do_update("post_rst", 7479, 47, 0, 23863, 47, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
